// File: rtl/mc_datapath.sv
// Multicycle 16-bit-instruction datapath with integrated sequencer and req/ack memory ports.
// Optional retired-instruction counter enabled by MC_DATAPATH_PERF_CNT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_FETCH  | ireq high, wait for iack, latch IR, PC += 2
// S_DECODE | read rs/rt into A/B; resolve halt, j and illegal opcodes
// S_EXEC   | ALU / address into ALUOut; resolve beq
// S_MEM    | dreq high until dack; sw retires, lw latches MDR
// S_WB     | write ALUOut or MDR to the register file and retire
// S_HALT   | absorbing; only reset leaves
module mc_datapath #(
   parameter int                DWIDTH   = 8,
   parameter int                IWIDTH   = 16,
   parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [DWIDTH-1:0] iaddr,
   output logic              ireq,
   input  logic              iack,
   input  logic [IWIDTH-1:0] irdata,
   output logic [DWIDTH-1:0] daddr,
   output logic              dreq,
   output logic              dwe,
   output logic [DWIDTH-1:0] dwdata,
   input  logic              dack,
   input  logic [DWIDTH-1:0] drdata,
   output logic [DWIDTH-1:0] pc,
   output logic              retire,
   output logic              halted,
   output logic              illegal,
   output logic [31:0]       icount
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_R    = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h2;
   localparam logic [3:0] OP_SW   = 4'h3;
   localparam logic [3:0] OP_BEQ  = 4'h4;
   localparam logic [3:0] OP_J    = 4'h5;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t            state;
   logic [IWIDTH-1:0] ir;
   logic [DWIDTH-1:0] a, b, alu_out, mdr;
   logic [DWIDTH-1:0] rf [0:3];

   logic [3:0]        op;
   logic [1:0]        rs, rt, rd;
   logic [2:0]        funct;
   logic [DWIDTH-1:0] sext_imm;
   logic              legal;
   logic [DWIDTH-1:0] alu_res, exec_res, br_target, wb_val;
   logic [1:0]        wb_dst;

   assign op       = ir[15:12];
   assign rs       = ir[11:10];
   assign rt       = ir[9:8];
   assign rd       = ir[7:6];
   assign funct    = ir[2:0];
   assign sext_imm = DWIDTH'($signed(ir[7:0]));
   assign legal    = (op <= OP_J) || (op == OP_HALT);

   always_comb begin
      case (funct)
         3'd1:    alu_res = a - b;
         3'd2:    alu_res = a & b;
         3'd3:    alu_res = a | b;
         3'd4:    alu_res = DWIDTH'({$signed(a) < $signed(b)});
         default: alu_res = a + b;
      endcase
   end

   // pc already holds PC_fetched + 2 by the time EXEC runs
   assign exec_res  = (op == OP_R) ? alu_res : a + sext_imm;
   assign br_target = pc + (sext_imm << 1);
   assign wb_dst    = (op == OP_R) ? rd : rt;
   assign wb_val    = (op == OP_LW) ? mdr : alu_out;

   assign iaddr  = pc;
   assign ireq   = reset && (state == S_FETCH);
   assign dreq   = reset && (state == S_MEM);
   assign dwe    = dreq && (op == OP_SW);
   assign daddr  = alu_out;
   assign dwdata = b;
   assign halted = (state == S_HALT);

   always_comb begin
      retire = 1'b0;
      case (state)
         S_DECODE: retire = (op == OP_J) || !legal;
         S_EXEC:   retire = (op == OP_BEQ);
         S_MEM:    retire = dack && (op == OP_SW);
         S_WB:     retire = 1'b1;
         default:  retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         illegal <= 1'b0;
         for (int i = 0; i < 4; i++) rf[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (iack) begin
                  ir    <= irdata;
                  pc    <= pc + DWIDTH'(2);
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               a <= rf[rs];
               b <= rf[rt];
               if (op == OP_HALT) begin
                  state <= S_HALT;
               end else if (op == OP_J) begin
                  pc    <= DWIDTH'(ir[11:0]);
                  state <= S_FETCH;
               end else if (!legal) begin
                  illegal <= 1'b1;
                  state   <= S_FETCH;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               alu_out <= exec_res;
               if (op == OP_BEQ) begin
                  if (a == b) pc <= br_target;
                  state <= S_FETCH;
               end else if ((op == OP_LW) || (op == OP_SW)) begin
                  state <= S_MEM;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (dack) begin
                  if (op == OP_SW) begin
                     state <= S_FETCH;
                  end else begin
                     mdr   <= drdata;
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (wb_dst != 2'd0) rf[wb_dst] <= wb_val;
               state <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef MC_DATAPATH_PERF_CNT_EN
   logic [31:0] icount_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) icount_q <= '0;
      else if (retire) icount_q <= icount_q + 32'd1;
   end

   assign icount = icount_q;
`else
   assign icount = 32'd0;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: random programs from wait-state memories,
// checked against an instruction-level reference model.
module tb_mc_datapath;

   localparam int         W     = 8;
   localparam logic [7:0] RST_PC = 8'h10;

   logic          clk, reset;
   logic [W-1:0]  iaddr, daddr, dwdata, drdata, pc;
   logic          ireq, iack, dreq, dwe, dack, retire, halted, illegal;
   logic [15:0]   irdata;
   logic [31:0]   icount;

   mc_datapath #(.DWIDTH(W), .IWIDTH(16), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset),
      .iaddr(iaddr), .ireq(ireq), .iack(iack), .irdata(irdata),
      .daddr(daddr), .dreq(dreq), .dwe(dwe), .dwdata(dwdata),
      .dack(dack), .drdata(drdata),
      .pc(pc), .retire(retire), .halted(halted), .illegal(illegal), .icount(icount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (instruction level) ----------------
   typedef struct { logic [7:0] next_pc; bit ill; int lat; } ret_t;
   typedef struct { bit we; logic [7:0] addr; logic [7:0] data; } mop_t;
   ret_t        ret_q[$];
   mop_t        mop_q[$];
   logic [7:0]  m_r [4];
   logic [7:0]  m_mem [256];
   logic [7:0]  dmem [256];
   logic [7:0]  m_pc;
   bit          m_ill;
   int          n_ret;

   function automatic int s8(input int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
      m_pc  = RST_PC;
      m_ill = 1'b0;
      n_ret = 0;
   endtask

   task automatic model_exec(input logic [15:0] ins);
      int         op  = int'(ins[15:12]);
      int         rt  = int'(ins[9:8]);
      int         rd  = int'(ins[7:6]);
      int         a   = int'(m_r[ins[11:10]]);
      int         b   = int'(m_r[ins[9:8]]);
      int         imm = s8(int'(ins[7:0]));
      int         res = 0;
      int         lat = -1;
      logic [7:0] nxt = m_pc + 8'd2;
      logic [7:0] addr = 8'(a + imm);
      mop_t       m;
      ret_t       r;
      case (op)
         0: begin
            case (ins[2:0])
               3'd1:    res = a - b;
               3'd2:    res = a & b;
               3'd3:    res = a | b;
               3'd4:    res = (s8(a) < s8(b)) ? 1 : 0;
               default: res = a + b;
            endcase
            if (rd != 0) m_r[rd] = 8'(res);
            lat = 3;
         end
         1: begin
            if (rt != 0) m_r[rt] = addr;
            lat = 3;
         end
         2: begin
            m = '{we: 1'b0, addr: addr, data: 8'd0};
            mop_q.push_back(m);
            if (rt != 0) m_r[rt] = m_mem[addr];
            lat = 4;
         end
         3: begin
            m = '{we: 1'b1, addr: addr, data: 8'(b)};
            mop_q.push_back(m);
            m_mem[addr] = 8'(b);
            lat = 3;
         end
         4: begin
            if (a == b) nxt = 8'(int'(nxt) + 2 * imm);
            lat = 2;
         end
         5: begin
            nxt = ins[7:0];
            lat = 1;
         end
         15: lat = -1;
         default: begin
            m_ill = 1'b1;
            lat   = 1;
         end
      endcase
      m_pc = nxt;
      if (lat >= 0) begin
         r = '{next_pc: nxt, ill: m_ill, lat: lat};
         ret_q.push_back(r);
      end
   endtask

   // ---------------- stimulus generator ----------------
   int          mode  = 0;   // 0 random, 1 halt, 2 stores only
   bit          dlong = 1'b0;
   logic [15:0] dir_q[$] = '{16'h1105, 16'h0580, 16'h3210, 16'h7000, 16'h40FE};

   task automatic gen(output logic [15:0] ins);
      logic [11:0] lo = 12'($urandom);
      int          k  = int'($urandom_range(0, 99));
      if (dir_q.size() > 0) ins = dir_q.pop_front();
      else if (mode == 1)   ins = {4'hF, lo};
      else if (mode == 2)   ins = {4'h3, lo};
      else if (k < 20)      ins = {4'h0, lo};
      else if (k < 40)      ins = {4'h1, lo};
      else if (k < 52)      ins = {4'h2, lo};
      else if (k < 72)      ins = {4'h3, lo};
      else if (k < 82)      ins = {4'h4, lo};
      else if (k < 87)      ins = {4'h5, lo};
      else if (k < 92)      ins = {4'($urandom_range(6, 14)), lo};
      else                  ins = {4'h1, lo};
   endtask

   // ---------------- memory responders (drive on negedge) ----------------
   int ack_cyc = 0, dwait_cur = 0;
   int iwait, dwait;
   bit ibusy = 1'b0, dbusy = 1'b0;

   initial begin
      logic [15:0] ins;
      mop_t        m;
      iack = 1'b0; dack = 1'b0; irdata = '0; drdata = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            iack = 1'b0; dack = 1'b0; ibusy = 1'b0; dbusy = 1'b0;
         end else begin
            if (ireq) begin
               if (!ibusy) begin
                  ibusy = 1'b1;
                  iwait = int'($urandom_range(0, 3));
               end
               if (iwait == 0) begin
                  chk("fetch_addr", 32'(iaddr), 32'(m_pc));
                  gen(ins);
                  iack = 1'b1; irdata = ins;
                  ack_cyc = cyc; dwait_cur = 0;
                  model_exec(ins);
                  ibusy = 1'b0;
               end else begin
                  iack = 1'b0;
                  iwait--;
               end
            end else begin
               ibusy  = 1'b0;
               iack   = ($urandom_range(0, 3) == 0);  // stray acks must be ignored
               irdata = 16'($urandom);
            end
            if (dreq) begin
               if (!dbusy) begin
                  dbusy = 1'b1;
                  dwait = dlong ? 8 : int'($urandom_range(0, 3));
                  dwait_cur = dwait;
               end
               if (dwait == 0) begin
                  dack = 1'b1;
                  if (mop_q.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL mem_unexpected: got access at 0x%0h, expected none", daddr);
                  end else begin
                     m = mop_q.pop_front();
                     chk("mem_we", 32'(dwe), 32'(m.we));
                     chk("mem_addr", 32'(daddr), 32'(m.addr));
                     if (m.we) chk("mem_wdata", 32'(dwdata), 32'(m.data));
                  end
                  if (dwe) dmem[daddr] = dwdata;
                  else drdata = dmem[daddr];
                  dbusy = 1'b0;
               end else begin
                  dack = 1'b0;
                  dwait--;
               end
            end else begin
               dbusy = 1'b0;
               dack  = 1'b0;
            end
         end
      end
   end

   // ---------------- retirement monitor ----------------
   initial begin
      ret_t r;
      forever begin
         @(negedge clk); #1;
         if (reset && retire) begin
            if (ret_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL retire_unexpected: got retire, expected none (t=%0t)", $time);
            end else begin
               r = ret_q.pop_front();
               n_ret++;
               chk("retire_latency", 32'(cyc - ack_cyc), 32'(r.lat + dwait_cur));
               @(negedge clk); #1;
               chk("retire_pulse", 32'(retire), 32'd0);
               chk("next_pc", 32'(pc), 32'(r.next_pc));
               chk("illegal_flag", 32'(illegal), 32'(r.ill));
`ifdef MC_DATAPATH_PERF_CNT_EN
               chk("icount", icount, 32'(n_ret));
`else
               chk("icount", icount, 32'd0);
`endif
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] st_addr;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         dmem[i]  = 8'($urandom);
         m_mem[i] = dmem[i];
      end
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pc", 32'(pc), 32'(RST_PC));
      chk("rst_ireq", 32'(ireq), 32'd0);
      chk("rst_dreq", 32'(dreq), 32'd0);
      chk("rst_dwe", 32'(dwe), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_icount", icount, 32'd0);
      reset = 1'b1;
      #1;
      chk("first_ireq", 32'(ireq), 32'd1);
      chk("first_iaddr", 32'(iaddr), 32'(RST_PC));

      for (int k = 0; k < 20000 && n_ret < 300; k++) @(negedge clk);
      chk("random_run_done", 32'(n_ret >= 300), 32'd1);

      mode = 1;
      for (int k = 0; k < 100 && !halted; k++) @(negedge clk);
      #2;
      chk("halt_reached", 32'(halted), 32'd1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #2;
         chk("halt_ireq", 32'(ireq), 32'd0);
         chk("halt_hold", 32'(halted), 32'd1);
      end
      chk("halt_pending_retires", 32'(ret_q.size()), 32'd0);

      @(negedge clk); #2;
      reset = 1'b0;
      ret_q.delete(); mop_q.delete();
      model_reset();
      mode = 2; dlong = 1'b1;
      @(negedge clk); #2;
      reset = 1'b1;
      for (int k = 0; k < 100 && !dreq; k++) @(negedge clk);
      #2;
      chk("store_pending", 32'(dreq), 32'd1);
      st_addr = daddr;
      dmem[st_addr] = 8'hA5;
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      chk("abort_dreq", 32'(dreq), 32'd0);
      chk("abort_dwe", 32'(dwe), 32'd0);
      chk("abort_pc", 32'(pc), 32'(RST_PC));
      chk("abort_ireq", 32'(ireq), 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_no_store", 32'(dmem[st_addr]), 32'h0000_00A5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
